// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - two-stage pipelined integer ALU with embedded ALU-control decode
module alu_exec_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ROB_WIDTH  = 5,
   parameter int PHY_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  issue_valid,
   output logic                  issue_ready,
   input  logic [6:0]            opcode,
   input  logic [2:0]            funct3,
   input  logic [6:0]            funct7,
   input  logic [DATA_WIDTH-1:0] rs1_data,
   input  logic [DATA_WIDTH-1:0] rs2_data,
   input  logic [DATA_WIDTH-1:0] imm,
   input  logic [DATA_WIDTH-1:0] pc,
   input  logic [ROB_WIDTH-1:0]  rob_id,
   input  logic [PHY_WIDTH-1:0]  rd_phy,
   output logic                  wb_valid,
   input  logic                  wb_ready,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic [ROB_WIDTH-1:0]  wb_rob_id,
   output logic [PHY_WIDTH-1:0]  wb_rd_phy,
   output logic                  busy
);

   localparam int SHW = $clog2(DATA_WIDTH);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // E1 capture registers
   logic                  e1_valid;
   logic [6:0]            e1_opcode;
   logic [2:0]            e1_funct3;
   logic [6:0]            e1_funct7;
   logic [DATA_WIDTH-1:0] e1_rs1;
   logic [DATA_WIDTH-1:0] e1_rs2;
   logic [DATA_WIDTH-1:0] e1_imm;
   logic [DATA_WIDTH-1:0] e1_pc;
   logic [ROB_WIDTH-1:0]  e1_rob;
   logic [PHY_WIDTH-1:0]  e1_rd;

   // E2 result registers drive the writeback port directly
   logic                  e2_valid;
   logic [DATA_WIDTH-1:0] e2_data;
   logic [ROB_WIDTH-1:0]  e2_rob;
   logic [PHY_WIDTH-1:0]  e2_rd;

   logic                  e2_consume;
   logic                  e1_advance;
   logic                  issue_fire;
   logic                  is_op;
   logic                  alt;
   logic [DATA_WIDTH-1:0] op_b;
   logic [SHW-1:0]        shamt;
   logic [DATA_WIDTH-1:0] result;
   logic                  unused_funct7_bits;

   // Only funct7[5] distinguishes SUB/SRA; other bits carry no meaning here
   assign unused_funct7_bits = ^{e1_funct7[6], e1_funct7[4:0]};

   // A flush hides the E2 result so nothing leaves during the kill cycle
   assign wb_valid    = e2_valid & ~flush;
   assign e2_consume  = wb_valid & wb_ready;
   assign e1_advance  = e1_valid & (~e2_valid | e2_consume) & ~flush;
   assign issue_ready = ~flush & (~e1_valid | e1_advance);
   assign issue_fire  = issue_valid & issue_ready;
   assign busy        = e1_valid | e2_valid;

   assign wb_data   = e2_data;
   assign wb_rob_id = e2_rob;
   assign wb_rd_phy = e2_rd;

   assign is_op = (e1_opcode == OPC_OP);
   assign alt   = e1_funct7[5];
   assign op_b  = is_op ? e1_rs2 : e1_imm;
   assign shamt = op_b[SHW-1:0];

   // ALU-control decode and operation select from the E1 registers
   always_comb begin
      result = '0;
      if (e1_opcode == OPC_LUI) begin
         result = e1_imm;
      end else if (e1_opcode == OPC_AUIPC) begin
         result = e1_pc + e1_imm;
      end else if (is_op || (e1_opcode == OPC_OP_IMM)) begin
         case (e1_funct3)
            3'b000:  result = (is_op && alt) ? (e1_rs1 - op_b) : (e1_rs1 + op_b);
            3'b001:  result = e1_rs1 << shamt;
            3'b010:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(e1_rs1) < $signed(op_b))};
            3'b011:  result = {{(DATA_WIDTH-1){1'b0}}, (e1_rs1 < op_b)};
            3'b100:  result = e1_rs1 ^ op_b;
            3'b101:  result = alt ? DATA_WIDTH'($signed(e1_rs1) >>> shamt) : (e1_rs1 >> shamt);
            3'b110:  result = e1_rs1 | op_b;
            default: result = e1_rs1 & op_b;
         endcase
      end else begin
         result = e1_rs1 + e1_rs2;
      end
   end

   // E1 stage: capture an issued instruction, empty on advance or flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e1_valid  <= 1'b0;
         e1_opcode <= '0;
         e1_funct3 <= '0;
         e1_funct7 <= '0;
         e1_rs1    <= '0;
         e1_rs2    <= '0;
         e1_imm    <= '0;
         e1_pc     <= '0;
         e1_rob    <= '0;
         e1_rd     <= '0;
      end else begin
         if (flush) begin
            e1_valid <= 1'b0;
         end else if (issue_fire) begin
            e1_valid <= 1'b1;
         end else if (e1_advance) begin
            e1_valid <= 1'b0;
         end
         if (issue_fire) begin
            e1_opcode <= opcode;
            e1_funct3 <= funct3;
            e1_funct7 <= funct7;
            e1_rs1    <= rs1_data;
            e1_rs2    <= rs2_data;
            e1_imm    <= imm;
            e1_pc     <= pc;
            e1_rob    <= rob_id;
            e1_rd     <= rd_phy;
         end
      end
   end

   // E2 stage: register the result, hold under backpressure, drop on consume or flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e2_valid <= 1'b0;
         e2_data  <= '0;
         e2_rob   <= '0;
         e2_rd    <= '0;
      end else if (flush) begin
         e2_valid <= 1'b0;
      end else if (e1_advance) begin
         e2_valid <= 1'b1;
         e2_data  <= result;
         e2_rob   <= e1_rob;
         e2_rd    <= e1_rd;
      end else if (e2_consume) begin
         e2_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard testbench for alu_exec_unit
module tb_alu_exec_unit;

   localparam logic [6:0] OP    = 7'b0110011;
   localparam logic [6:0] OPI   = 7'b0010011;
   localparam logic [6:0] LUI   = 7'b0110111;
   localparam logic [6:0] AUIPC = 7'b0010111;
   localparam logic [6:0] LOAD  = 7'b0000011;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rob;
      logic [5:0]  rd;
   } exp_t;

   logic        clk, rst, flush, issue_valid, issue_ready;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [31:0] rs1_data, rs2_data, imm, pc;
   logic [4:0]  rob_id;
   logic [5:0]  rd_phy;
   logic        wb_valid, wb_ready, busy;
   logic [31:0] wb_data;
   logic [4:0]  wb_rob_id;
   logic [5:0]  wb_rd_phy;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_next;
   exp_t sb[$];

   alu_exec_unit #(.DATA_WIDTH(32), .ROB_WIDTH(5), .PHY_WIDTH(6)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
      .rob_id(rob_id), .rd_phy(rd_phy),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
      .wb_rob_id(wb_rob_id), .wb_rd_phy(wb_rd_phy), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: pops expected results on every writeback handshake, pushes on every issue handshake
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
      end else begin
         if (wb_valid && wb_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL stale_result: got data 0x%08h rob %0d with nothing expected", wb_data, wb_rob_id);
            end else begin
               e = sb.pop_front();
               if (wb_data !== e.data || wb_rob_id !== e.rob || wb_rd_phy !== e.rd) begin
                  errors++;
                  $display("FAIL wb_result: got 0x%08h/%0d/%0d expected 0x%08h/%0d/%0d",
                           wb_data, wb_rob_id, wb_rd_phy, e.data, e.rob, e.rd);
               end
            end
         end
         if (flush) sb.delete();
         if (issue_valid && issue_ready) sb.push_back(exp_next);
      end
   end

   // Present an instruction at the inputs together with its hand-computed result
   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic [31:0] p, input logic [4:0] rob, input logic [5:0] rd,
                        input logic [31:0] expv);
      issue_valid = 1'b1;
      opcode = op; funct3 = f3; funct7 = f7;
      rs1_data = a; rs2_data = b; imm = im; pc = p;
      rob_id = rob; rd_phy = rd;
      exp_next = '{data: expv, rob: rob, rd: rd};
   endtask

   // Drive and wait for the issue handshake; returns just after the accepting edge
   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic [31:0] p, input logic [4:0] rob, input logic [5:0] rd,
                        input logic [31:0] expv);
      bit ok = 0;
      drive(op, f3, f7, a, b, im, p, rob, rd, expv);
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = issue_ready;
         @(posedge clk);
         #1;
      end
      issue_valid = 1'b0;
      if (!ok) check("issue_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_empty", sb.size(), 0);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; wb_ready = 1'b1;
      opcode = '0; funct3 = '0; funct7 = '0;
      rs1_data = '0; rs2_data = '0; imm = '0; pc = '0; rob_id = '0; rd_phy = '0;
      exp_next = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_wb_valid", wb_valid, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_wb_rob", wb_rob_id, 0);
      check("rst_wb_rd", wb_rd_phy, 0);
      check("rst_busy", busy, 0);
      check("rst_issue_ready", issue_ready, 1);
      rst = 1'b0;
      cyc();

      // ADD with latency check
      issue(OP, 3'b000, 7'h00, 32'd5, 32'd7, 32'd0, 32'd0, 5'd1, 6'd11, 32'd12);
      @(negedge clk);
      check("lat_not_early", wb_valid, 0);
      @(posedge clk);
      @(negedge clk);
      check("lat_wb_valid", wb_valid, 1);
      check("lat_wb_data", wb_data, 32'd12);
      check("lat_wb_rob", wb_rob_id, 5'd1);
      check("lat_wb_rd", wb_rd_phy, 6'd11);
      cyc();

      // Back-to-back directed vectors at full throughput
      issue(OP,    3'b000, 7'h20, 32'd5,        32'd7,  32'd0,        32'd0,      5'd2,  6'd12, 32'hFFFF_FFFE);
      issue(OPI,   3'b101, 7'h20, 32'h8000_0000, 32'd0, 32'd4,        32'd0,      5'd3,  6'd13, 32'hF800_0000);
      issue(OPI,   3'b101, 7'h00, 32'h8000_0000, 32'd0, 32'd4,        32'd0,      5'd4,  6'd14, 32'h0800_0000);
      issue(OP,    3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0,        32'd0,      5'd5,  6'd15, 32'd1);
      issue(OP,    3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0,        32'd0,      5'd6,  6'd16, 32'd0);
      issue(LUI,   3'b000, 7'h00, 32'd99,        32'd9, 32'h1234_5000, 32'd0,     5'd7,  6'd17, 32'h1234_5000);
      issue(AUIPC, 3'b000, 7'h00, 32'd99,        32'd9, 32'h0000_2000, 32'h1000,  5'd8,  6'd18, 32'h0000_3000);
      issue(OPI,   3'b000, 7'h20, 32'd10,        32'd9, 32'd3,        32'd0,      5'd9,  6'd19, 32'd13);
      issue(OP,    3'b001, 7'h00, 32'd1,         32'd35, 32'd0,       32'd0,      5'd10, 6'd20, 32'd8);
      issue(OP,    3'b100, 7'h00, 32'hF0F0_0FF0, 32'h0FF0_0FF0, 32'd0, 32'd0,     5'd11, 6'd21, 32'hFF00_0000);
      issue(OPI,   3'b110, 7'h00, 32'h0000_00F0, 32'd0, 32'h0000_000F, 32'd0,     5'd12, 6'd22, 32'h0000_00FF);
      issue(OPI,   3'b111, 7'h00, 32'h0000_0FF0, 32'd0, 32'h0000_00FF, 32'd0,     5'd13, 6'd23, 32'h0000_00F0);
      issue(LOAD,  3'b010, 7'h20, 32'd4,         32'd9, 32'd100,      32'd0,      5'd14, 6'd24, 32'd13);
      drain();

      // Backpressure: three back-to-back with wb_ready low
      wb_ready = 1'b0;
      drive(OP, 3'b000, 7'h00, 32'd100, 32'd1, 32'd0, 32'd0, 5'd20, 6'd30, 32'd101);
      @(negedge clk);
      check("bp_ready_1", issue_ready, 1);
      cyc();
      drive(OP, 3'b000, 7'h00, 32'd200, 32'd2, 32'd0, 32'd0, 5'd21, 6'd31, 32'd202);
      @(negedge clk);
      check("bp_ready_2", issue_ready, 1);
      cyc();
      drive(OP, 3'b000, 7'h00, 32'd300, 32'd3, 32'd0, 32'd0, 5'd22, 6'd32, 32'd303);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_ready_3_blocked", issue_ready, 0);
         check("bp_hold_valid", wb_valid, 1);
         check("bp_hold_data", wb_data, 32'd101);
         cyc();
      end
      wb_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", issue_ready, 1);
      cyc();
      issue_valid = 1'b0;
      @(negedge clk);
      check("bp_second_next", wb_data, 32'd202);
      cyc();
      @(negedge clk);
      check("bp_third_next", wb_data, 32'd303);
      drain();

      // Flush with both stages full; an issue attempt during the flush must not be taken
      wb_ready = 1'b0;
      issue(OP, 3'b000, 7'h00, 32'd7, 32'd7, 32'd0, 32'd0, 5'd25, 6'd40, 32'd14);
      issue(OP, 3'b000, 7'h00, 32'd8, 32'd8, 32'd0, 32'd0, 5'd26, 6'd41, 32'd16);
      @(negedge clk);
      check("fl_pre_busy", busy, 1);
      cyc();
      flush = 1'b1;
      drive(OP, 3'b000, 7'h00, 32'd9, 32'd9, 32'd0, 32'd0, 5'd27, 6'd42, 32'd18);
      wb_ready = 1'b1;
      @(negedge clk);
      check("fl_wb_valid", wb_valid, 0);
      check("fl_issue_ready", issue_ready, 0);
      cyc();
      flush = 1'b0;
      issue_valid = 1'b0;
      @(negedge clk);
      check("fl_busy_after", busy, 0);
      check("fl_wb_after", wb_valid, 0);
      repeat (3) cyc();
      issue(OP, 3'b000, 7'h00, 32'd1, 32'd1, 32'd0, 32'd0, 5'd28, 6'd43, 32'd2);
      drain();

      // Asynchronous reset while a result is waiting
      wb_ready = 1'b0;
      issue(OP, 3'b000, 7'h00, 32'd40, 32'd2, 32'd0, 32'd0, 5'd29, 6'd44, 32'd42);
      cyc();
      @(negedge clk);
      check("rs_pre_valid", wb_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("rs_wb_valid", wb_valid, 0);
      check("rs_busy", busy, 0);
      check("rs_wb_data", wb_data, 0);
      check("rs_wb_rob", wb_rob_id, 0);
      check("rs_wb_rd", wb_rd_phy, 0);
      cyc();
      cyc();
      rst = 1'b0;
      wb_ready = 1'b1;
      @(negedge clk);
      check("rs_issue_ready", issue_ready, 1);
      repeat (4) cyc();
      check("rs_no_output", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Two-stage pipelined integer ALU execution unit that sits directly downstream of the issue queue and embeds the ALU-control decode for OP, OP_IMM, LUI and AUIPC instructions. It accepts one issued instruction per cycle with its operands, ROB tag and destination physical register. It computes the result and presents it to the writeback/CDB arbiter through a valid/ready handshake. It supports backpressure and a branch-misprediction flush.

## Interface
- DATA_WIDTH, 32, operand/result width (power of two)
- ROB_WIDTH, 5, ROB tag width
- PHY_WIDTH, 6, physical register index width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  kill all in-flight work (mispredict)
- issue_valid  in  1  issue slot holds an instruction
- issue_ready  out  1  unit can accept this cycle
- opcode  in  7  RV32 opcode
- funct3  in  3  RV32 funct3
- funct7  in  7  RV32 funct7 (imm[11:5] for OP_IMM)
- rs1_data  in  DATA_WIDTH  source operand 1
- rs2_data  in  DATA_WIDTH  source operand 2
- imm  in  DATA_WIDTH  sign-extended immediate (U-type already shifted)
- pc  in  DATA_WIDTH  instruction PC
- rob_id  in  ROB_WIDTH  ROB tag
- rd_phy  in  PHY_WIDTH  destination physical register
- wb_valid  out  1  result available
- wb_ready  in  1  arbiter consumes result
- wb_data  out  DATA_WIDTH  result
- wb_rob_id  out  ROB_WIDTH  tag of result
- wb_rd_phy  out  PHY_WIDTH  destination of result
- busy  out  1  either stage occupied

## Operation
- Stage E1 (capture): on an issue handshake (issue_valid & issue_ready), register all inputs and set e1_valid.
- Stage E2 (execute): when E1 advances, the selected operation's result is registered along with the tag and rd, and e2_valid is set.
- Decode (combinational from E1 regs) follows the team's ALU-control encoding:
  - OP: funct3 selects ADD/SUB (funct7[5]), SLL, SLT, SLTU, XOR, SRL/SRA (funct7[5]), OR, AND.
  - OP_IMM: same selection, except funct3=000 is always ADD (no SUBI).
  - LUI: result = imm.
  - AUIPC: result = pc + imm.
  - Any other opcode: ADD of rs1 and rs2.
- Operand B is rs2_data for OP, imm otherwise.
- Shift amount is B[log2(DATA_WIDTH)-1:0]. SLT is signed, SLTU unsigned; both produce 0/1 zero-extended.
- All add/sub results wrap modulo 2^DATA_WIDTH. No overflow flag.
- Advance rules:
  - E2 loads when E2 is empty or is being consumed (wb_valid & wb_ready).
  - E1 loads when E1 is empty or is advancing into E2.
  - issue_ready = ~flush & (~e1_valid | e1_advance).
- Flush: at the next edge, e1_valid and e2_valid are cleared.
  - During the flush cycle, issue_ready=0 and wb_valid=0; no handshake occurs on either side.
- Simultaneous consume and issue: with both stages full and wb_ready=1, the E2 result leaves, E1 moves to E2 and a new instruction enters E1 on the same edge.
- busy = e1_valid | e2_valid.

## Timing
- Reset values:
  - e1_valid=0, e2_valid=0, all data/tag registers 0.
  - wb_valid=0, wb_data=0, wb_rob_id=0, wb_rd_phy=0, busy=0.
  - issue_ready=1 (when flush=0).
- Latency:
  - Instruction accepted at edge k gives wb_valid=1 after edge k+1.
  - wb_data/wb_rob_id/wb_rd_phy are registered outputs, stable while wb_valid=1 and wb_ready=0.
- Throughput: 1 instruction/cycle with wb_ready held high.
- Backpressure:
  - With wb_ready=0, E2 holds and E1 fills. issue_ready then drops in the cycle after the second accept.
  - At most 2 instructions are in flight.
- Reset asserted mid-operation clears everything asynchronously. No result is emitted after release.

## Test plan
- ADD/SUB: OP funct3=000, rs1=5, rs2=7, funct7=0x00 -> wb_data=12. With funct7=0x20 -> wb_data=0xFFFFFFFE. wb_valid one cycle after accept, wb_rob_id/wb_rd_phy match.
- Shifts/compare:
  - OP_IMM SRAI (funct3=101, funct7=0x20), rs1=0x80000000, imm=4 -> 0xF8000000.
  - SRLI -> 0x08000000.
  - SLT rs1=-1, rs2=1 -> 1; SLTU with the same operands -> 0.
- LUI/AUIPC: LUI imm=0x12345000 -> 0x12345000. AUIPC pc=0x1000, imm=0x2000 -> 0x3000.
- Backpressure:
  - Hold wb_ready=0 and issue 3 back-to-back: first two accepted, issue_ready=0 on the third.
  - Release wb_ready: results appear in order on consecutive cycles, third accepted one cycle later.
- Flush:
  - With both stages full, assert flush for 1 cycle -> wb_valid=0 that cycle and afterwards, busy=0 next cycle, no stale result ever emitted.
  - The next issued ADD 1+1 -> 2.
- Reset mid-stream: assert rst asynchronously while wb_valid=1 -> wb_valid and busy drop immediately, outputs read 0, issue_ready=1 after release.
